// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite renderer.
package sprite_pkg;

  localparam int unsigned PIPE_LAT = 3;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DONE
  } anim_state_t;

  typedef logic [11:0] rgb12_t;

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: steps cur_frame once every FRAME_TICKS video frames.
// Start/stop requests are held pending and only take effect on frame_tick.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_FRAMES  = 4,
  parameter int unsigned FRAME_TICKS = 6,
  parameter int unsigned FR_W        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic            vga_clk,
  input  logic            Reset,
  input  logic            frame_tick,
  input  logic            anim_start,
  input  logic            anim_stop,
  input  logic            anim_loop,
  output logic [FR_W-1:0] cur_frame,
  output logic            anim_done
);

  localparam int unsigned CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

  anim_state_t      state, state_nxt;
  logic [CNT_W-1:0] tick_cnt, tick_cnt_nxt;
  logic [FR_W-1:0]  frame_nxt;
  logic             start_pend, start_pend_nxt;
  logic             stop_pend, stop_pend_nxt;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      cur_frame  <= '0;
      start_pend <= 1'b0;
      stop_pend  <= 1'b0;
    end else begin
      state      <= state_nxt;
      tick_cnt   <= tick_cnt_nxt;
      cur_frame  <= frame_nxt;
      start_pend <= start_pend_nxt;
      stop_pend  <= stop_pend_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    tick_cnt_nxt   = tick_cnt;
    frame_nxt      = cur_frame;
    start_pend_nxt = start_pend;
    stop_pend_nxt  = stop_pend;

    if (frame_tick) begin
      start_pend_nxt = 1'b0;
      stop_pend_nxt  = 1'b0;
      // pending stop outranks a pending start
      if (stop_pend) begin
        state_nxt    = IDLE;
        frame_nxt    = '0;
        tick_cnt_nxt = '0;
      end else if (start_pend) begin
        state_nxt    = PLAY;
        frame_nxt    = '0;
        tick_cnt_nxt = '0;
      end else begin
        unique case (state)
          PLAY: begin
            if (tick_cnt == CNT_W'(FRAME_TICKS - 1)) begin
              tick_cnt_nxt = '0;
              if (cur_frame == FR_W'(NUM_FRAMES - 1)) begin
                if (anim_loop) frame_nxt = '0;
                else           state_nxt = DONE;
              end else begin
                frame_nxt = cur_frame + FR_W'(1);
              end
            end else begin
              tick_cnt_nxt = tick_cnt + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // requests arriving with a tick are kept for the following tick
    if (anim_stop) begin
      stop_pend_nxt  = 1'b1;
      start_pend_nxt = 1'b0;
    end else if (anim_start) begin
      start_pend_nxt = 1'b1;
      stop_pend_nxt  = 1'b0;
    end
  end

  assign anim_done = (state == DONE);

endmodule

// File: rtl/sprite_anim_renderer.sv
// Multi-frame sprite renderer with placement, mirroring and transparency.
// Define SPRITE_SCALE2_EN to draw the sprite at 2x size (nearest neighbour).
module sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter  int unsigned SPRITE_W    = 50,
  parameter  int unsigned SPRITE_H    = 64,
  parameter  int unsigned NUM_FRAMES  = 4,
  parameter  int unsigned IDX_W       = 3,
  parameter  int unsigned FRAME_TICKS = 6,
  parameter  int unsigned TRANSP_IDX  = 0,
  localparam int unsigned ADDR_W      = $clog2(NUM_FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic              vga_clk,
  input  logic              Reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              frame_tick,
  input  logic [9:0]        PosX,
  input  logic [9:0]        PosY,
  input  logic              flip,
  input  logic              anim_start,
  input  logic              anim_loop,
  input  logic              anim_stop,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [11:0]       pal_rgb,
  output logic              pixel_on,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              anim_done
);

  localparam int unsigned FR_W      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int unsigned FRAME_PIX = SPRITE_W * SPRITE_H;
`ifdef SPRITE_SCALE2_EN
  localparam int unsigned SCALE = 2;
`else
  localparam int unsigned SCALE = 1;
`endif
  localparam int unsigned FOOT_W = SPRITE_W * SCALE;
  localparam int unsigned FOOT_H = SPRITE_H * SCALE;

  logic [FR_W-1:0] cur_frame;

  sprite_anim_ctrl #(
    .NUM_FRAMES  (NUM_FRAMES),
    .FRAME_TICKS (FRAME_TICKS),
    .FR_W        (FR_W)
  ) u_ctrl (
    .vga_clk    (vga_clk),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .anim_start (anim_start),
    .anim_stop  (anim_stop),
    .anim_loop  (anim_loop),
    .cur_frame  (cur_frame),
    .anim_done  (anim_done)
  );

  logic [9:0] pos_x, pos_y;
  logic       flip_q;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pos_x  <= '0;
      pos_y  <= '0;
      flip_q <= 1'b0;
    end else if (frame_tick) begin
      pos_x  <= PosX;
      pos_y  <= PosY;
      flip_q <= flip;
    end
  end

  // 11-bit compare so a sprite near the right edge clips instead of wrapping
  logic [10:0] x11, y11, px11, py11;
  logic        hit;

  always_comb begin
    x11  = {1'b0, DrawX};
    y11  = {1'b0, DrawY};
    px11 = {1'b0, pos_x};
    py11 = {1'b0, pos_y};
    hit  = (x11 >= px11) && (x11 < px11 + 11'(FOOT_W)) &&
           (y11 >= py11) && (y11 < py11 + 11'(FOOT_H));
  end

  logic [9:0]        rel_x, rel_y, src_x, dx, dy;
  logic [ADDR_W-1:0] addr_nxt;

  always_comb begin
    rel_x = DrawX - pos_x;
    rel_y = DrawY - pos_y;
`ifdef SPRITE_SCALE2_EN
    src_x = rel_x >> 1;
    dy    = rel_y >> 1;
`else
    src_x = rel_x;
    dy    = rel_y;
`endif
    dx       = flip_q ? (10'(SPRITE_W - 1) - src_x) : src_x;
    addr_nxt = ADDR_W'(cur_frame) * ADDR_W'(FRAME_PIX)
             + ADDR_W'(dy) * ADDR_W'(SPRITE_W)
             + ADDR_W'(dx);
  end

  // hit/blank ride alongside the ROM access; last tap lines up with rom_q
  logic [PIPE_LAT-2:0] hit_sr, blank_sr;
  logic                pix_vis;
  rgb12_t              rgb_q;

  assign pix_vis = hit_sr[PIPE_LAT-2] & blank_sr[PIPE_LAT-2] &
                   (rom_q != IDX_W'(TRANSP_IDX));

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      rom_addr <= '0;
      hit_sr   <= '0;
      blank_sr <= '0;
      pixel_on <= 1'b0;
      rgb_q    <= '0;
    end else begin
      if (hit) rom_addr <= addr_nxt;
      hit_sr   <= {hit_sr[PIPE_LAT-3:0], hit};
      blank_sr <= {blank_sr[PIPE_LAT-3:0], blank};
      pixel_on <= pix_vis;
      rgb_q    <= pix_vis ? rgb12_t'(pal_rgb) : '0;
    end
  end

  assign pal_idx = rom_q;
  assign red     = rgb_q[11:8];
  assign green   = rgb_q[7:4];
  assign blue    = rgb_q[3:0];

endmodule

// File: doc/sprite_anim_renderer.md
Name: sprite_anim_renderer

Overview:
- Parametrised multi-frame sprite renderer for the VGA pipeline; successor to the single-image full-screen sprite example.
- Places a W×H sprite at a runtime position, with optional horizontal mirroring.
- Steps through NUM_FRAMES animation frames stored back to back in one external synchronous ROM, and flags transparent pixels so the compositor can layer sprites.
- Sits between the sprite ROM/palette and the screen compositor; one instance per animated character.

Parameters:
- SPRITE_W, 50, sprite width in pixels
- SPRITE_H, 64, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored consecutively in ROM
- IDX_W, 3, palette index width (ROM data width)
- FRAME_TICKS, 6, video frames each animation frame is shown (≥1)
- TRANSP_IDX, 0, palette index treated as transparent

Ports:
- vga_clk  in  1  pixel clock; all state on posedge
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current scan X
- DrawY  in  10  current scan Y
- blank  in  1  high = active video (codebase polarity)
- frame_tick  in  1  one-cycle pulse per video frame, at vsync
- PosX  in  10  sprite top-left X, sampled on frame_tick
- PosY  in  10  sprite top-left Y, sampled on frame_tick
- flip  in  1  1 = mirror horizontally, sampled on frame_tick
- anim_start  in  1  pulse: request play from frame 0
- anim_loop  in  1  1 = wrap after last frame, 0 = one-shot
- anim_stop  in  1  pulse: return to idle
- rom_addr  out  ADDR_W  address to external sync ROM, ADDR_W = $clog2(NUM_FRAMES*SPRITE_W*SPRITE_H)
- rom_q  in  IDX_W  ROM data, valid one cycle after rom_addr
- pal_idx  out  IDX_W  palette index, equal to rom_q
- pal_rgb  in  12  combinational palette output {r,g,b}
- pixel_on  out  1  registered: sprite covers pixel, not transparent, blank high
- red  out  4  registered
- green  out  4  registered
- blue  out  4  registered
- anim_done  out  1  high while in DONE state

Behaviour:
- Reset: state IDLE, cur_frame=0, tick_cnt=0, start_pend=0, latched pos/flip=0, rom_addr=0, pixel_on=0, RGB=0, anim_done=0.
- FSM (advances only on frame_tick):
  - IDLE: holds frame 0. On tick with start_pend → PLAY, frame 0, tick_cnt 0.
  - PLAY: tick_cnt increments; at FRAME_TICKS-1 it clears and frame advances.
  - End of PLAY: at last frame with wrap due, anim_loop=1 → frame 0; anim_loop=0 → DONE, holding the last frame.
  - DONE: anim_done=1. start_pend → PLAY.
- anim_start sets start_pend at any cycle; start_pend is consumed on the next frame_tick, so there are no mid-frame frame changes (no tearing).
- anim_start during PLAY restarts at frame 0 on the next tick.
- anim_stop has priority over a same-cycle or pending start. It clears start_pend, and on the next tick → IDLE, frame 0.
- PosX, PosY and flip are latched on frame_tick only.
- Hit test: DrawX ≥ PX, DrawX < PX+SPRITE_W, DrawY ≥ PY, DrawY < PY+SPRITE_H. Compare at 11 bits, so PX+W past 639 simply clips and does not wrap.
- Offsets: dx = flip ? SPRITE_W-1-(DrawX-PX) : DrawX-PX; dy = DrawY-PY.
- Address: rom_addr = cur_frame*W*H + dy*W + dx. Multipliers are constant, so no runtime divide.
- Pipeline, latency 3 from DrawX/DrawY to outputs:
  - Edge 1 registers rom_addr and hit_d1/blank_d1.
  - ROM samples at edge 2; hit_d2/blank_d2 follow.
  - Edge 3 registers pixel_on = hit_d2 & blank_d2 & (rom_q≠TRANSP_IDX), and RGB = pixel_on ? pal_rgb : 0.
- No hit: rom_addr holds its previous value (saves ROM toggling) and outputs are 0.

Optional Feature:
- Macro SPRITE_SCALE2_EN.
- Defined: on-screen footprint 2W×2H. Offsets become dx=(DrawX-PX)>>1 and dy=(DrawY-PY)>>1 before flip; flip uses the scaled offset. Nearest-neighbour, same latency.
- Undefined: 1:1 mapping as above.

Decomposition:
- Package sprite_pkg: PIPE_LAT=3, the anim_state_t enum (IDLE, PLAY, DONE), and the 12-bit rgb12_t typedef.
- Sub-module sprite_anim_ctrl holds the FSM, tick_cnt, cur_frame and start_pend. It outputs cur_frame and anim_done.
- The address and pixel pipeline stays in the top module.

Test Plan:
- Reset mid-PLAY with cur_frame=2: after one edge, frame=0, IDLE, pixel_on=0, RGB=0.
- PosX=100, PosY=50, flip=0, DrawX=100, DrawY=50, frame 0: rom_addr=0, and outputs appear 3 cycles later. With flip=1: rom_addr=49. At DrawX=149 flip=0: rom_addr=49. At DrawX=150: pixel_on=0.
- FRAME_TICKS=6, anim_loop=1, start: frame sequence 0,1,2,3,0 changing every 6 ticks. With anim_loop=0: stops at 3 with anim_done=1 after tick 24.
- frame 2, DrawX=PX+3, DrawY=PY+1: rom_addr=2*3200+50+3=6453. rom_q=TRANSP_IDX → pixel_on=0.
- anim_start and anim_stop in the same cycle: next tick → IDLE, frame 0. anim_start mid-scan: cur_frame unchanged until frame_tick.
- PosX=620 (clip): DrawX 620..639 draw; no wrap to X=0..29 on the next line. SPRITE_SCALE2_EN: DrawX=PX+7 gives dx=3.
